gmii_loopback_tester: RTL and testbench

//  Synthesizable GMII traffic generator and checker for board-level Ethernet loopback (PHY or cable).

---
 rtl/gmii_lb_pkg.sv | 30 +++
 rtl/gmii_lb_if.sv | 14 +
 rtl/gmii_lb_rx_checker.sv | 130 +++++++++++++
 rtl/gmii_loopback_tester.sv | 176 +++++++++++++++++
 tb/tb_gmii_loopback_tester.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gmii_lb_pkg.sv
// Shared constants, state encodings and the length-sweep helper for the GMII loopback tester.
package gmii_lb_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int unsigned LEN_W        = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_PRE,
        TX_SFD,
        TX_DATA,
        TX_IFG,
        TX_DRAIN
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_PRE,
        RX_DATA,
        RX_DROP
    } rx_state_e;

    function automatic logic [LEN_W-1:0] next_len(input logic [LEN_W-1:0] len,
                                                  input logic [LEN_W-1:0] lmin,
                                                  input logic [LEN_W-1:0] lmax);
        return (len >= lmax) ? lmin : len + LEN_W'(1);
    endfunction

endpackage

// File: rtl/gmii_lb_if.sv
// GMII pin bundle; master is the tester side, slave is the PHY/loopback side.
interface gmii_lb_if;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;

    modport master (output gmii_txd, gmii_tx_en, gmii_tx_er,
                    input  gmii_rxd, gmii_rx_dv, gmii_rx_er);
    modport slave  (input  gmii_txd, gmii_tx_en, gmii_tx_er,
                    output gmii_rxd, gmii_rx_dv, gmii_rx_er);
endinterface

// File: rtl/gmii_lb_rx_checker.sv
// Receive-side checker: tracks the expected sequence/length per frame and counts good/bad frames.
module gmii_lb_rx_checker
    import gmii_lb_pkg::*;
#(
    parameter int unsigned LEN_MIN = 64,
    parameter int unsigned LEN_MAX = 1518,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [7:0]       rxd,
    input  logic             rx_dv,
    input  logic             rx_er,
    output logic [CNT_W-1:0] rx_ok,
    output logic [CNT_W-1:0] rx_bad
);

    rx_state_e        state_q, state_d;
    logic [7:0]       exp_seq_q, exp_seq_d;
    logic [LEN_W-1:0] exp_len_q, exp_len_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             mis_q, mis_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] ok_q, ok_d;
    logic [CNT_W-1:0] bad_q, bad_d;
    logic             frame_end;
    logic             frame_good;

    always_comb begin
        state_d    = state_q;
        exp_seq_d  = exp_seq_q;
        exp_len_d  = exp_len_q;
        byte_cnt_d = byte_cnt_q;
        mis_d      = mis_q;
        err_d      = err_q;
        ok_d       = ok_q;
        bad_d      = bad_q;
        frame_end  = 1'b0;
        frame_good = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_dv && rxd == PREAMBLE_BYTE) begin
                    state_d = RX_PRE;
                    err_d   = rx_er;
                end
            end
            RX_PRE: begin
                if (!rx_dv) begin
                    state_d = RX_IDLE;
                end else if (rxd == SFD_BYTE) begin
                    state_d    = RX_DATA;
                    byte_cnt_d = '0;
                    mis_d      = 1'b0;
                    err_d      = err_q | rx_er;
                end else if (rxd != PREAMBLE_BYTE) begin
                    state_d = RX_DROP;
                end else begin
                    err_d = err_q | rx_er;
                end
            end
            RX_DATA: begin
                if (rx_dv) begin
                    if (rxd != exp_seq_q + byte_cnt_q[7:0]) mis_d = 1'b1;
                    if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    err_d = err_q | rx_er;
                end else begin
                    frame_end  = 1'b1;
                    frame_good = !mis_q && !err_q && (byte_cnt_q == exp_len_q);
                    state_d    = RX_IDLE;
                end
            end
            RX_DROP: begin
                if (!rx_dv) begin
                    frame_end = 1'b1;
                    state_d   = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // Every terminated frame, good or bad, consumes one expected slot so the sequence stays locked.
        if (frame_end) begin
            exp_seq_d = exp_seq_q + 8'd1;
            exp_len_d = next_len(exp_len_q, LEN_W'(LEN_MIN), LEN_W'(LEN_MAX));
            if (frame_good) begin
                if (ok_q != '1) ok_d = ok_q + CNT_W'(1);
            end else if (bad_q != '1) begin
                bad_d = bad_q + CNT_W'(1);
            end
        end

        if (clear) begin
            state_d    = RX_IDLE;
            exp_seq_d  = '0;
            exp_len_d  = LEN_W'(LEN_MIN);
            byte_cnt_d = '0;
            mis_d      = 1'b0;
            err_d      = 1'b0;
            ok_d       = '0;
            bad_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RX_IDLE;
            exp_seq_q  <= '0;
            exp_len_q  <= LEN_W'(LEN_MIN);
            byte_cnt_q <= '0;
            mis_q      <= 1'b0;
            err_q      <= 1'b0;
            ok_q       <= '0;
            bad_q      <= '0;
        end else begin
            state_q    <= state_d;
            exp_seq_q  <= exp_seq_d;
            exp_len_q  <= exp_len_d;
            byte_cnt_q <= byte_cnt_d;
            mis_q      <= mis_d;
            err_q      <= err_d;
            ok_q       <= ok_d;
            bad_q      <= bad_d;
        end
    end

    assign rx_ok  = ok_q;
    assign rx_bad = bad_q;

endmodule

// File: rtl/gmii_loopback_tester.sv
// GMII loopback traffic generator: TX framing FSM, run control and drain/timeout handling.
// Looped-back frames are checked by gmii_lb_rx_checker on the TX clock.
module gmii_loopback_tester
    import gmii_lb_pkg::*;
#(
    parameter int unsigned LEN_MIN    = 64,
    parameter int unsigned LEN_MAX    = 1518,
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned PRE_LEN    = 7,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RX_TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] frame_count,
    gmii_lb_if.master        gmii,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tx_frames,
    output logic [CNT_W-1:0] rx_ok,
    output logic [CNT_W-1:0] rx_bad
);

    tx_state_e        state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       seq_q, seq_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             stop_q, stop_d;
    logic [7:0]       txd_q, txd_d;
    logic             tx_en_q, tx_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_ok;
    logic [CNT_W:0]   rx_sum;

    assign start_ok = start && (state_q == TX_IDLE);
    assign rx_sum   = {1'b0, rx_ok} + {1'b0, rx_bad};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seq_d    = seq_q;
        len_d    = len_q;
        frames_d = frames_q;
        stop_d   = stop_q | (stop & busy_q);
        txd_d    = '0;
        tx_en_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        // Output registers are loaded from the next state so the first preamble byte follows start by one cycle.
        case (state_q)
            TX_IDLE: begin
                if (start_ok) begin
                    state_d  = TX_PRE;
                    cnt_d    = LEN_W'(1);
                    seq_d    = '0;
                    len_d    = LEN_W'(LEN_MIN);
                    frames_d = '0;
                    stop_d   = stop;
                    busy_d   = 1'b1;
                    tx_en_d  = 1'b1;
                    txd_d    = PREAMBLE_BYTE;
                end
            end
            TX_PRE: begin
                tx_en_d = 1'b1;
                if (cnt_q == LEN_W'(PRE_LEN)) begin
                    state_d = TX_SFD;
                    txd_d   = SFD_BYTE;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                    txd_d = PREAMBLE_BYTE;
                end
            end
            TX_SFD: begin
                state_d = TX_DATA;
                cnt_d   = LEN_W'(1);
                tx_en_d = 1'b1;
                txd_d   = seq_q;
            end
            TX_DATA: begin
                if (cnt_q == len_q) begin
                    state_d  = TX_IFG;
                    cnt_d    = LEN_W'(1);
                    frames_d = (frames_q == '1) ? frames_q : frames_q + CNT_W'(1);
                    seq_d    = seq_q + 8'd1;
                    len_d    = next_len(len_q, LEN_W'(LEN_MIN), LEN_W'(LEN_MAX));
                end else begin
                    cnt_d   = cnt_q + LEN_W'(1);
                    tx_en_d = 1'b1;
                    txd_d   = seq_q + cnt_q[7:0];
                end
            end
            TX_IFG: begin
                if (cnt_q == LEN_W'(IFG_CYCLES)) begin
                    if (stop_q || stop || (frame_count != '0 && frames_q == frame_count)) begin
                        state_d = TX_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        state_d = TX_PRE;
                        cnt_d   = LEN_W'(1);
                        tx_en_d = 1'b1;
                        txd_d   = PREAMBLE_BYTE;
                    end
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            TX_DRAIN: begin
                if (rx_sum == {1'b0, frames_q} || cnt_q == LEN_W'(RX_TIMEOUT)) begin
                    state_d = TX_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (gmii.gmii_rx_dv) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= TX_IDLE;
            cnt_q    <= '0;
            seq_q    <= '0;
            len_q    <= LEN_W'(LEN_MIN);
            frames_q <= '0;
            stop_q   <= 1'b0;
            txd_q    <= '0;
            tx_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seq_q    <= seq_d;
            len_q    <= len_d;
            frames_q <= frames_d;
            stop_q   <= stop_d;
            txd_q    <= txd_d;
            tx_en_q  <= tx_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    gmii_lb_rx_checker #(
        .LEN_MIN (LEN_MIN),
        .LEN_MAX (LEN_MAX),
        .CNT_W   (CNT_W)
    ) u_rx_checker (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_ok),
        .rxd    (gmii.gmii_rxd),
        .rx_dv  (gmii.gmii_rx_dv),
        .rx_er  (gmii.gmii_rx_er),
        .rx_ok  (rx_ok),
        .rx_bad (rx_bad)
    );

    assign gmii.gmii_txd   = txd_q;
    assign gmii.gmii_tx_en = tx_en_q;
    assign gmii.gmii_tx_er = 1'b0;
    assign busy            = busy_q;
    assign done            = done_q;
    assign tx_frames       = frames_q;

endmodule

// File: tb/tb_gmii_loopback_tester.sv
// Scoreboard bench for gmii_loopback_tester: loopback path with fault injection, frame and run-end monitors.
`timescale 1ns/1ps
module tb_gmii_loopback_tester;

    localparam int unsigned LEN_MIN = 64;
    localparam int unsigned LEN_MAX = 66;
    localparam int unsigned IFG     = 12;
    localparam int unsigned PRE     = 7;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned RX_TO   = 256;

    typedef struct {
        int seq;
        int len;
    } frame_t;

    typedef struct {
        int tx;
        int ok;
        int bad;
        int lat_lo;
        int lat_hi;
    } done_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [CNT_W-1:0] frame_count = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] tx_frames;
    logic [CNT_W-1:0] rx_ok;
    logic [CNT_W-1:0] rx_bad;

    int n_checks = 0;
    int n_fail = 0;

    frame_t exp_frames[$];
    done_t  exp_done[$];

    int corrupt_frame = -1;
    int corrupt_pos = 0;
    int er_frame = -1;
    int er_pos = 0;
    int drop_frame = -1;

    int lb_frame = -1;
    int lb_pos = 0;
    bit lb_prev_en = 1'b0;

    logic [7:0] cap[$];
    bit     capturing = 1'b0;
    bit     have_prev = 1'b0;
    bit     er_seen = 1'b0;
    int     gap = 0;
    done_t  cur_done;
    frame_t cur_frame;

    gmii_lb_if gi();

    gmii_loopback_tester #(
        .LEN_MIN    (LEN_MIN),
        .LEN_MAX    (LEN_MAX),
        .IFG_CYCLES (IFG),
        .PRE_LEN    (PRE),
        .CNT_W      (CNT_W),
        .RX_TIMEOUT (RX_TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .frame_count (frame_count),
        .gmii        (gi),
        .busy        (busy),
        .done        (done),
        .tx_frames   (tx_frames),
        .rx_ok       (rx_ok),
        .rx_bad      (rx_bad)
    );

    always #4 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Expected frames of a run restart at seq 0 / LEN_MIN and sweep LEN_MIN..LEN_MAX.
    task automatic expect_run(input int nfr, input int ok, input int bad, input bit timeout,
                              input bit with_done);
        frame_t f;
        done_t  d;
        int     len = LEN_MIN;
        for (int i = 0; i < nfr; i++) begin
            f.seq = i % 256;
            f.len = len;
            exp_frames.push_back(f);
            len = (len == LEN_MAX) ? LEN_MIN : len + 1;
        end
        if (with_done) begin
            d.tx     = nfr;
            d.ok     = ok;
            d.bad    = bad;
            d.lat_lo = timeout ? RX_TO : IFG + 1;
            d.lat_hi = timeout ? RX_TO + IFG + 8 : IFG + 6;
            exp_done.push_back(d);
        end
    endtask

    task automatic pulse_start(input logic with_stop);
        @(posedge clk);
        #1 start = 1'b1;
        stop = with_stop;
        @(posedge clk);
        #1 start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (n < limit) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        check(name, done, 1);
        #2;
        check({name, "_busy_low"}, busy, 0);
        check({name, "_frames_left"}, exp_frames.size(), 0);
        check({name, "_done_left"}, exp_done.size(), 0);
    endtask

    task automatic wait_frame_start(input int n, input int limit);
        int seen = 0;
        int cyc = 0;
        bit prev = 1'b0;
        while (seen < n && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (gi.gmii_tx_en && !prev) seen++;
            prev = gi.gmii_tx_en;
        end
        check("frame_start_seen", seen, n);
    endtask

    task automatic check_frame();
        int bad_pre = 0;
        int bad_pay = 0;
        check("frame_expected", exp_frames.size() > 0, 1);
        if (exp_frames.size() == 0) return;
        cur_frame = exp_frames.pop_front();
        check("frame_len", cap.size(), PRE + 1 + cur_frame.len);
        check("tx_er_low", er_seen, 0);
        for (int i = 0; i < int'(PRE); i++)
            if (i < cap.size() && cap[i] != 8'h55) bad_pre++;
        check("preamble", bad_pre, 0);
        if (cap.size() > PRE + 1) begin
            check("sfd", cap[PRE], 8'hD5);
            check("first_byte", cap[PRE+1], cur_frame.seq);
        end
        for (int k = 0; k < cur_frame.len; k++)
            if (PRE + 1 + k < cap.size() && cap[PRE+1+k] != 8'((cur_frame.seq + k) % 256)) bad_pay++;
        check("payload", bad_pay, 0);
    endtask

    // Loopback cable model: TX copied to RX with one cycle of delay, plus fault injection.
    initial begin
        gi.gmii_rxd   = '0;
        gi.gmii_rx_dv = 1'b0;
        gi.gmii_rx_er = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy) lb_frame = -1;
            if (gi.gmii_tx_en && !lb_prev_en) begin
                lb_frame++;
                lb_pos = 0;
            end
            lb_prev_en    = gi.gmii_tx_en;
            gi.gmii_rxd   = gi.gmii_txd;
            gi.gmii_rx_dv = gi.gmii_tx_en;
            gi.gmii_rx_er = 1'b0;
            if (gi.gmii_tx_en) begin
                if (lb_frame == corrupt_frame && lb_pos == corrupt_pos) gi.gmii_rxd = gi.gmii_txd ^ 8'hFF;
                if (lb_frame == er_frame && lb_pos == er_pos) gi.gmii_rx_er = 1'b1;
                if (lb_frame == drop_frame) begin
                    gi.gmii_rx_dv = 1'b0;
                    gi.gmii_rxd   = '0;
                end
                lb_pos++;
            end
        end
    end

    // Monitor: captures each TX frame, checks gaps, and scores run-end counters on done.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cap.delete();
                capturing = 1'b0;
                have_prev = 1'b0;
                er_seen   = 1'b0;
                gap       = 0;
                continue;
            end
            if (gi.gmii_tx_en) begin
                if (!capturing && have_prev) check("ifg_gap", gap, IFG);
                capturing = 1'b1;
                cap.push_back(gi.gmii_txd);
                if (gi.gmii_tx_er) er_seen = 1'b1;
            end else begin
                if (capturing) begin
                    capturing = 1'b0;
                    check_frame();
                    cap.delete();
                    er_seen   = 1'b0;
                    have_prev = 1'b1;
                    gap       = 0;
                end
                gap++;
            end
            if (done) begin
                check("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    cur_done = exp_done.pop_front();
                    check("tx_frames", tx_frames, cur_done.tx);
                    check("rx_ok", rx_ok, cur_done.ok);
                    check("rx_bad", rx_bad, cur_done.bad);
                    check_range("done_latency", gap, cur_done.lat_lo, cur_done.lat_hi);
                end
                have_prev = 1'b0;
            end
        end
    end

    initial begin
        #3;
        check("rst_tx_en", gi.gmii_tx_en, 0);
        check("rst_txd", gi.gmii_txd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_frames", tx_frames, 0);
        check("rst_rx_ok", rx_ok, 0);
        check("rst_rx_bad", rx_bad, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_tx_en", gi.gmii_tx_en, 0);

        // Plain loopback, three frames.
        frame_count = 3;
        expect_run(3, 3, 0, 0, 1);
        pulse_start(0);
        wait_done("t1_done", 2000);

        // One corrupted payload byte in the second frame.
        corrupt_frame = 1;
        corrupt_pos   = PRE + 1 + 10;
        expect_run(3, 2, 1, 0, 1);
        pulse_start(0);
        wait_done("t2_done", 2000);
        corrupt_frame = -1;

        // rx_er for one cycle in the first frame.
        frame_count = 2;
        er_frame    = 0;
        er_pos      = PRE + 1 + 5;
        expect_run(2, 1, 1, 0, 1);
        pulse_start(0);
        wait_done("t3a_done", 2000);
        er_frame = -1;

        // Second frame lost entirely: run ends on the receive timeout.
        drop_frame = 1;
        expect_run(2, 1, 0, 1, 1);
        pulse_start(0);
        wait_done("t3b_done", 2000);
        drop_frame = -1;

        // Length sweep wrap over five frames; a start while busy must be ignored.
        frame_count = 5;
        expect_run(5, 5, 0, 0, 1);
        pulse_start(0);
        wait_frame_start(2, 400);
        pulse_start(0);
        wait_done("t4_done", 2000);

        // Continuous mode, stop in the middle of the fourth frame.
        frame_count = 0;
        expect_run(4, 4, 0, 0, 1);
        pulse_start(0);
        wait_frame_start(4, 800);
        repeat (20) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        wait_done("t5_done", 2000);

        // start and stop together: exactly one frame.
        expect_run(1, 1, 0, 0, 1);
        pulse_start(1);
        wait_done("t7_done", 2000);

        // Asynchronous reset in the middle of the second frame, then a clean run.
        frame_count = 3;
        expect_run(1, 0, 0, 0, 0);
        pulse_start(0);
        wait_frame_start(2, 400);
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_tx_en", gi.gmii_tx_en, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_tx_frames", tx_frames, 0);
        check("t6_rst_rx_ok", rx_ok, 0);
        check("t6_rst_rx_bad", rx_bad, 0);
        check("t6_frames_left", exp_frames.size(), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_run(3, 3, 0, 0, 1);
        pulse_start(0);
        wait_done("t6_done", 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
